mmio_uart_bridge: RTL and testbench
===================================

Name: mmio_uart_bridge

Overview:
- Parametrised successor to the core's memory-map controller.
- Decodes a relocatable MMIO window of UART registers.
- Passes every other address through to the instruction/data memory unchanged.
- Adds buffering the previous controller lacked: a TX FIFO and an RX FIFO, each FIFO_DEPTH deep, plus sticky error flags and a status register.
- Sits between the single-cycle core's data port and the UART TX/RX engines.

Parameters:
- DATA_WIDTH, 32, core data/address width.
- BASE_ADDR, 32'h10010024, word address of register 0 of the MMIO window.
- FIFO_DEPTH, 8, entries per FIFO; power of two, minimum 2.
- CHAR_WIDTH, 8, UART character width; must be ≤ DATA_WIDTH-8.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low.
- Address  in  DATA_WIDTH  core byte address.
- WriteData_in  in  DATA_WIDTH  core store data.
- MemWrite  in  1  core store strobe, one cycle per store.
- MemRead  in  1  core load strobe, one cycle per load.
- ReadData  out  DATA_WIDTH  load data to core, combinational.
- ID_Address  out  DATA_WIDTH  memory address: Address when not in the window, else 0.
- WriteData_out  out  DATA_WIDTH  equals WriteData_in always.
- ID_MemWrite  out  1  MemWrite gated to non-window addresses.
- ID_ReadData  in  DATA_WIDTH  memory load data.
- tx_char  out  CHAR_WIDTH  TX FIFO head.
- tx_valid  out  1  TX FIFO not empty.
- tx_ready  in  1  TX engine accepts; a char pops on tx_valid & tx_ready.
- rx_char  in  CHAR_WIDTH  received character.
- rx_valid  in  1  one-cycle pulse; pushes rx_char into the RX FIFO.

Behaviour:
- Clocking and reset:
  - One clock domain (clk).
  - Reset is synchronous and active-low: when reset==0 at a rising clk edge, all state clears.
  - Reset clears FIFO pointers and counts to 0, rx_ovf=0, tx_drop=0.
  - Outputs after reset: tx_valid=0, tx_char=0; ReadData reflects the empty state.
  - Reset mid-operation discards FIFO contents; no partial transfer survives.
- Register map, offsets from BASE_ADDR (window = BASE_ADDR..BASE_ADDR+0x0C, word-aligned exact match only):
  - +0x0 STATUS (RO):
    - bit0 rx_nonempty, bit1 tx_full, bit2 rx_ovf, bit3 tx_empty, bit4 tx_drop.
    - bits[15:8] rx_count, zero-extended.
    - bits[23:16] tx_count, zero-extended.
    - Other bits 0.
  - +0x4 TX_DATA (WO):
    - A store pushes WriteData_in[CHAR_WIDTH-1:0].
    - If the TX FIFO is full, the byte is dropped and tx_drop is set.
    - Reads return 0.
  - +0x8 RX_DATA (RO):
    - Reads return the RX head, zero-extended; 0 if empty.
    - MemRead pops the head at the clock edge; a pop on empty is a no-op.
  - +0xC CTRL (WO):
    - A store with bit0=1 clears rx_ovf, bit1=1 clears tx_drop, bit2=1 flushes the RX FIFO.
    - Reads return 0.
- Address decode:
  - Addresses outside the window go to memory: ReadData=ID_ReadData, ID_MemWrite=MemWrite, ID_Address=Address.
  - Inside the window: ID_MemWrite=0, ID_Address=0.
  - MemWrite to RO registers and MemRead of WO registers have no side effect.
- Latency:
  - ReadData is combinational from current registered state.
  - Pushes and pops commit at the next rising edge.
  - A TX push makes tx_valid rise the cycle after the push edge (push→valid latency 1).
- FIFOs:
  - Circular, with log2(FIFO_DEPTH)-bit pointers that wrap modulo FIFO_DEPTH.
  - Count is log2(FIFO_DEPTH)+1 bits.
  - full = (count==FIFO_DEPTH); empty = (count==0).
- RX simultaneous events:
  - Push and pop in the same cycle, FIFO non-empty: both occur, count unchanged.
  - Same cycle with the FIFO full: both occur, no rx_ovf.
  - Same cycle with the FIFO empty: the pop is a no-op and the push succeeds.
  - Push while full without a pop: char dropped, rx_ovf=1 (sticky).
  - Flush plus an rx_valid push in the same cycle: flush wins, the char is dropped, rx_ovf unchanged.
  - CTRL clear of rx_ovf and a new overflow in the same cycle: set wins.
- TX simultaneous events:
  - Core push and engine pop in the same cycle: both occur.
  - Same cycle with the FIFO full: both occur, no tx_drop.
  - CTRL clear of tx_drop and a new drop in the same cycle: set wins.
- tx_char is the registered head; it is held stable while tx_valid & !tx_ready.

Test Plan:
1. Reset with reset=0 for 2 cycles → tx_valid=0; STATUS reads 32'h0000_0008; ID_MemWrite follows MemWrite for Address=32'h1001_0000.
2. Store 0x41, 0x42, 0x43 to 32'h10010028 with tx_ready=0 → STATUS[23:16]=3. Then raise tx_ready → tx_char sequence 0x41, 0x42, 0x43 on consecutive cycles, then tx_valid=0, tx_empty=1.
3. Issue 9 rx_valid pulses (chars 0x10..0x18), FIFO_DEPTH=8 → rx_count=8, rx_ovf=1. Eight RX_DATA loads (32'h1001002C) return 0x10..0x17; a ninth returns 0; STATUS bit0=0.
4. With the RX FIFO full, assert rx_valid (0x55) and an RX_DATA load in the same cycle → load returns the old head, count stays 8, rx_ovf stays 0. Later CTRL store of 0x1 with a simultaneous overflow → rx_ovf remains 1.
5. Fill the TX FIFO to 8, then store 0x99 → tx_drop=1 and count stays 8. CTRL store of 0x2 → tx_drop=0. Pushes 8+4 entries across a drain confirm pointer wrap-around with order preserved.
6. Load 5 RX chars, then store CTRL 0x4 in the same cycle as an rx_valid → rx_count=0, that char lost, rx_ovf=0. Assert reset mid-TX-drain → tx_valid=0 the next cycle.

Source files
------------

// File: rtl/mmio_uart_bridge.sv
// mmio_uart_bridge: relocatable UART register window with TX/RX FIFOs in front of data memory
module mmio_uart_bridge #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR  = 32'h10010024,
    parameter int                    FIFO_DEPTH = 8,
    parameter int                    CHAR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] WriteData_in,
    input  logic                  MemWrite,
    input  logic                  MemRead,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic [DATA_WIDTH-1:0] ID_Address,
    output logic [DATA_WIDTH-1:0] WriteData_out,
    output logic                  ID_MemWrite,
    input  logic [DATA_WIDTH-1:0] ID_ReadData,
    output logic [CHAR_WIDTH-1:0] tx_char,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [CHAR_WIDTH-1:0] rx_char,
    input  logic                  rx_valid
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    logic [CHAR_WIDTH-1:0] r_tx_mem [FIFO_DEPTH];
    logic [CHAR_WIDTH-1:0] r_rx_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_tx_wr, r_tx_rd, r_rx_wr, r_rx_rd;
    logic [CW-1:0]         r_tx_count, r_rx_count;
    logic                  r_rx_ovf, r_tx_drop;

    logic w_sel_st, w_sel_tx, w_sel_rx, w_sel_ct, w_in_win;
    logic w_tx_full, w_tx_empty, w_rx_full, w_rx_nonempty;
    logic w_tx_push, w_tx_pop, w_tx_drop, w_clr_drop;
    logic w_rx_push, w_rx_pop, w_rx_ovf, w_clr_ovf, w_rx_flush, w_ctrl_wr;
    logic [23:0]           w_status_lo;
    logic [DATA_WIDTH-1:0] w_status, w_rx_data;

    assign w_sel_st = Address == BASE_ADDR;
    assign w_sel_tx = Address == BASE_ADDR + DATA_WIDTH'(4);
    assign w_sel_rx = Address == BASE_ADDR + DATA_WIDTH'(8);
    assign w_sel_ct = Address == BASE_ADDR + DATA_WIDTH'(12);
    assign w_in_win = w_sel_st | w_sel_tx | w_sel_rx | w_sel_ct;

    assign w_tx_full     = r_tx_count == FULL;
    assign w_tx_empty    = r_tx_count == '0;
    assign w_rx_full     = r_rx_count == FULL;
    assign w_rx_nonempty = r_rx_count != '0;

    assign w_ctrl_wr  = MemWrite & w_sel_ct;
    assign w_clr_ovf  = w_ctrl_wr & WriteData_in[0];
    assign w_clr_drop = w_ctrl_wr & WriteData_in[1];
    assign w_rx_flush = w_ctrl_wr & WriteData_in[2];

    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands
    assign w_tx_pop  = tx_valid & tx_ready;
    assign w_tx_push = MemWrite & w_sel_tx & (!w_tx_full | w_tx_pop);
    assign w_tx_drop = MemWrite & w_sel_tx & w_tx_full & !w_tx_pop;

    assign w_rx_pop  = MemRead & w_sel_rx & w_rx_nonempty;
    assign w_rx_push = rx_valid & !w_rx_flush & (!w_rx_full | w_rx_pop);
    assign w_rx_ovf  = rx_valid & !w_rx_flush & w_rx_full & !w_rx_pop;

    assign w_status_lo = {8'(r_tx_count), 8'(r_rx_count), 3'b000,
                          r_tx_drop, w_tx_empty, r_rx_ovf, w_tx_full, w_rx_nonempty};
    assign w_status    = DATA_WIDTH'(w_status_lo);
    assign w_rx_data   = w_rx_nonempty ? DATA_WIDTH'(r_rx_mem[r_rx_rd]) : '0;

    assign tx_valid = !w_tx_empty;
    assign tx_char  = tx_valid ? r_tx_mem[r_tx_rd] : '0;

    always_comb begin
        ReadData      = !w_in_win ? ID_ReadData : w_sel_st ? w_status : w_sel_rx ? w_rx_data : '0;
        ID_Address    = w_in_win ? '0 : Address;
        ID_MemWrite   = MemWrite & !w_in_win;
        WriteData_out = WriteData_in;
    end

    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wr] <= WriteData_in[CHAR_WIDTH-1:0];
        if (w_rx_push) r_rx_mem[r_rx_wr] <= rx_char;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tx_wr    <= '0;
            r_tx_rd    <= '0;
            r_tx_count <= '0;
            r_rx_wr    <= '0;
            r_rx_rd    <= '0;
            r_rx_count <= '0;
            r_rx_ovf   <= 1'b0;
            r_tx_drop  <= 1'b0;
        end else begin
            r_tx_wr    <= r_tx_wr + AW'(w_tx_push);
            r_tx_rd    <= r_tx_rd + AW'(w_tx_pop);
            r_tx_count <= r_tx_count + CW'(w_tx_push) - CW'(w_tx_pop);
            r_rx_wr    <= w_rx_flush ? '0 : r_rx_wr + AW'(w_rx_push);
            r_rx_rd    <= w_rx_flush ? '0 : r_rx_rd + AW'(w_rx_pop);
            r_rx_count <= w_rx_flush ? '0 : r_rx_count + CW'(w_rx_push) - CW'(w_rx_pop);
            r_rx_ovf   <= w_rx_ovf | (r_rx_ovf & !w_clr_ovf);
            r_tx_drop  <= w_tx_drop | (r_tx_drop & !w_clr_drop);
        end
    end
endmodule

// File: tb/tb_mmio_uart_bridge.sv
// tb_mmio_uart_bridge: directed stimulus with queued expectations checked by a negedge monitor
module tb_mmio_uart_bridge;
    localparam logic [31:0] ST = 32'h10010024;
    localparam logic [31:0] TX = 32'h10010028;
    localparam logic [31:0] RX = 32'h1001002C;
    localparam logic [31:0] CT = 32'h10010030;

    typedef struct {
        string       nm;
        logic [31:0] v;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] Address = '0, WriteData_in = '0, ID_ReadData = '0;
    logic        MemWrite = 1'b0, MemRead = 1'b0;
    logic [31:0] ReadData, ID_Address, WriteData_out;
    logic        ID_MemWrite, tx_valid;
    logic [7:0]  tx_char;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_char = '0;
    logic        rx_valid = 1'b0;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t rd_q[$];
    exp_t tx_q[$];
    exp_t mon_e;

    mmio_uart_bridge dut (
        .clk(clk), .reset(reset), .Address(Address), .WriteData_in(WriteData_in),
        .MemWrite(MemWrite), .MemRead(MemRead), .ReadData(ReadData), .ID_Address(ID_Address),
        .WriteData_out(WriteData_out), .ID_MemWrite(ID_MemWrite), .ID_ReadData(ID_ReadData),
        .tx_char(tx_char), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_char(rx_char), .rx_valid(rx_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every load and every TX handshake consumes the next expectation
    always @(negedge clk) begin
        if (MemRead) begin
            if (rd_q.size() == 0) chk("rd_unexpected", ReadData, 32'hxxxx_xxxx);
            else begin
                mon_e = rd_q.pop_front();
                chk(mon_e.nm, ReadData, mon_e.v);
            end
        end
        if (tx_valid && tx_ready) begin
            if (tx_q.size() == 0) chk("tx_unexpected", 32'(tx_char), 32'hxxxx_xxxx);
            else begin
                mon_e = tx_q.pop_front();
                chk(mon_e.nm, 32'(tx_char), mon_e.v);
            end
        end
    end

    task automatic rd(input logic [31:0] a, input logic [31:0] v, input string nm);
        Address = a;
        MemRead = 1'b1;
        rd_q.push_back('{nm, v});
        @(posedge clk);
        #1;
        MemRead = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        Address = a;
        WriteData_in = d;
        MemWrite = 1'b1;
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
    endtask

    task automatic rxp(input logic [7:0] c);
        rx_char = c;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic txe(input logic [7:0] c);
        tx_q.push_back('{"tx_char", 32'(c)});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset, decode and pass-through
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        chk("rst_tx_valid", 32'(tx_valid), 0);
        chk("rst_tx_char", 32'(tx_char), 0);
        rd(ST, 32'h0000_0008, "rst_status");
        Address = 32'h1001_0000;
        WriteData_in = 32'hDEAD_BEEF;
        MemWrite = 1'b1;
        #1;
        chk("mem_we", 32'(ID_MemWrite), 1);
        chk("mem_addr", ID_Address, 32'h1001_0000);
        chk("wdata_out", WriteData_out, 32'hDEAD_BEEF);
        Address = ST;
        #1;
        chk("win_we", 32'(ID_MemWrite), 0);
        chk("win_addr", ID_Address, 0);
        MemWrite = 1'b0;
        ID_ReadData = 32'hCAFE_BABE;
        rd(32'h1001_0000, 32'hCAFE_BABE, "mem_rd");
        rd(32'h1001_0034, 32'hCAFE_BABE, "above_win_rd");
        rd(32'h1001_0020, 32'hCAFE_BABE, "below_win_rd");
        rd(32'h1001_0025, 32'hCAFE_BABE, "unaligned_rd");
        // 2: TX ordering and push->valid latency
        wr(TX, 32'h41);
        chk("tx_valid_lat", 32'(tx_valid), 1);
        chk("tx_head", 32'(tx_char), 32'h41);
        wr(TX, 32'h42);
        wr(TX, 32'h43);
        rd(ST, 32'h0003_0000, "status_tx3");
        rd(TX, 32'h0, "txdata_rd0");
        rd(CT, 32'h0, "ctrl_rd0");
        txe(8'h41); txe(8'h42); txe(8'h43);
        tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tx_ready = 1'b0;
        chk("tx_drained", 32'(tx_valid), 0);
        rd(ST, 32'h0000_0008, "status_tx_empty");
        // 3: RX fill, overflow, drain
        for (int i = 0; i < 9; i++) rxp(8'(8'h10 + i));
        rd(ST, 32'h0000_080D, "status_rx_ovf");
        for (int i = 0; i < 8; i++) rd(RX, 32'h10 + i, "rx_data");
        rd(RX, 32'h0, "rx_empty_rd");
        rd(ST, 32'h0000_000C, "status_rx_drained");
        wr(CT, 32'h1);
        rd(ST, 32'h0000_0008, "status_ovf_clr");
        // 4: RX push+pop while full, clear vs new overflow
        for (int i = 0; i < 8; i++) rxp(8'(8'h20 + i));
        rd(ST, 32'h0000_0809, "status_rx_full");
        rx_char = 8'h55;
        rx_valid = 1'b1;
        rd(RX, 32'h20, "rx_pushpop_full");
        rx_valid = 1'b0;
        rd(ST, 32'h0000_0809, "status_pushpop");
        rx_char = 8'h66;
        rx_valid = 1'b1;
        wr(CT, 32'h1);
        rx_valid = 1'b0;
        rd(ST, 32'h0000_080D, "status_ovf_set_wins");
        for (int i = 1; i < 8; i++) rd(RX, 32'h20 + i, "rx_data2");
        rd(RX, 32'h55, "rx_late_push");
        wr(CT, 32'h1);
        rd(ST, 32'h0000_0008, "status_clean");
        // 5: TX full, drop, clear, simultaneous push+pop, wrap-around
        for (int i = 0; i < 8; i++) wr(TX, 32'h80 + i);
        rd(ST, 32'h0008_0002, "status_tx_full");
        wr(TX, 32'h99);
        rd(ST, 32'h0008_0012, "status_tx_drop");
        wr(CT, 32'h2);
        rd(ST, 32'h0008_0002, "status_drop_clr");
        txe(8'h80);
        tx_ready = 1'b1;
        wr(TX, 32'hA0);
        tx_ready = 1'b0;
        rd(ST, 32'h0008_0002, "status_full_pushpop");
        for (int i = 1; i < 8; i++) txe(8'(8'h80 + i));
        for (int i = 0; i < 4; i++) txe(8'(8'hA0 + i));
        tx_ready = 1'b1;
        for (int i = 1; i < 4; i++) wr(TX, 32'hA0 + i);
        repeat (8) @(posedge clk);
        #1;
        tx_ready = 1'b0;
        chk("tx_wrap_drained", 32'(tx_valid), 0);
        rd(ST, 32'h0000_0008, "status_wrap_done");
        // 6: flush beats simultaneous push; reset mid-drain
        for (int i = 0; i < 5; i++) rxp(8'(8'h30 + i));
        rd(ST, 32'h0000_0509, "status_rx5");
        rx_char = 8'h77;
        rx_valid = 1'b1;
        wr(CT, 32'h4);
        rx_valid = 1'b0;
        rd(ST, 32'h0000_0008, "status_flushed");
        rd(RX, 32'h0, "rx_after_flush");
        rxp(8'h35);
        rd(RX, 32'h35, "rx_post_flush");
        wr(TX, 32'hB0);
        wr(TX, 32'hB1);
        wr(TX, 32'hB2);
        txe(8'hB0); txe(8'hB1);
        tx_ready = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_tx_valid", 32'(tx_valid), 0);
        chk("reset_tx_char", 32'(tx_char), 0);
        tx_ready = 1'b0;
        reset = 1'b1;
        rd(ST, 32'h0000_0008, "status_after_reset");
        @(posedge clk);
        #1;
        chk("rd_q_left", rd_q.size(), 0);
        chk("tx_q_left", tx_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
